// File: rtl/map_table_if.sv
// Rename map table port bundle.
//   master : dispatch/rollback/retire/CDB inputs driven in, renamed tags observed
//   slave  : the map table itself
// Groups: dispatch (dispatch_en, dest/src indices, T_idx), recovery (rollback_en),
// completion (CDB_*), retirement (retire_*), rename results (T1/T2/Told).
interface map_table_if #(
  parameter int NUM_SUPER = 2,
  parameter int AR_W      = 5,
  parameter int PR_W      = 6
);
  logic                             dispatch_en;
  logic                             rollback_en;
  logic [NUM_SUPER-1:0][AR_W-1:0]   dest_idx;
  logic [NUM_SUPER-1:0][AR_W-1:0]   srcA_idx;
  logic [NUM_SUPER-1:0][AR_W-1:0]   srcB_idx;
  logic [NUM_SUPER-1:0][PR_W-1:0]   T_idx;
  logic [NUM_SUPER-1:0]             CDB_valid;
  logic [NUM_SUPER-1:0][PR_W-1:0]   CDB_T_idx;
  logic [NUM_SUPER-1:0]             retire_en;
  logic [NUM_SUPER-1:0][AR_W-1:0]   retire_dest_idx;
  logic [NUM_SUPER-1:0][PR_W-1:0]   retire_T_idx;
  logic [NUM_SUPER-1:0][PR_W-1:0]   T1_idx;
  logic [NUM_SUPER-1:0][PR_W-1:0]   T2_idx;
  logic [NUM_SUPER-1:0]             T1_ready;
  logic [NUM_SUPER-1:0]             T2_ready;
  logic [NUM_SUPER-1:0][PR_W-1:0]   Told_idx;

  modport master (
    output dispatch_en, rollback_en, dest_idx, srcA_idx, srcB_idx, T_idx,
           CDB_valid, CDB_T_idx, retire_en, retire_dest_idx, retire_T_idx,
    input  T1_idx, T2_idx, T1_ready, T2_ready, Told_idx
  );

  modport slave (
    input  dispatch_en, rollback_en, dest_idx, srcA_idx, srcB_idx, T_idx,
           CDB_valid, CDB_T_idx, retire_en, retire_dest_idx, retire_T_idx,
    output T1_idx, T2_idx, T1_ready, T2_ready, Told_idx
  );
endinterface

// File: rtl/map_table.sv
// map_table: superscalar register rename map table.
//   clock, reset : system clock, synchronous active-high reset
//   mt (slave)   : dispatch group in, renamed source tags / ready / Told out,
//                  CDB wakeup, ROB retire updates, rollback to the retirement map.
// Speculative map + ready bits drive renaming; the retirement map tracks the
// committed state and is copied into the speculative map on rollback.

// Resolves one source operand: zero register, intra-group bypass, or table
// lookup with same-cycle CDB wakeup.
module map_table_src #(
  parameter int NUM_SUPER = 2,
  parameter int AR_W      = 5,
  parameter int PR_W      = 6,
  parameter int ZERO_REG  = 31,
  parameter int ZERO_PR   = 31
) (
  input  logic [AR_W-1:0]                 src,
  input  logic [PR_W-1:0]                 tbl_tag,
  input  logic                            tbl_rdy,
  input  logic                            byp_hit,
  input  logic [PR_W-1:0]                 byp_tag,
  input  logic [NUM_SUPER-1:0]            cdb_valid,
  input  logic [NUM_SUPER-1:0][PR_W-1:0]  cdb_tag,
  output logic [PR_W-1:0]                 tag,
  output logic                            rdy
);
  logic cdb_hit;

  always_comb begin
    cdb_hit = 1'b0;
    for (int l = 0; l < NUM_SUPER; l++)
      if (cdb_valid[l] && cdb_tag[l] != PR_W'(ZERO_PR) && cdb_tag[l] == tbl_tag)
        cdb_hit = 1'b1;
    if (src == AR_W'(ZERO_REG)) begin
      tag = PR_W'(ZERO_PR);
      rdy = 1'b1;
    end else if (byp_hit) begin
      // producer is in this same group, so it cannot have completed yet
      tag = byp_tag;
      rdy = 1'b0;
    end else begin
      tag = tbl_tag;
      rdy = tbl_rdy | cdb_hit;
    end
  end
endmodule

module map_table #(
  parameter int NUM_SUPER = 2,
  parameter int NUM_ARCH  = 32,
  parameter int NUM_PR    = 64,
  parameter int ZERO_REG  = 31,
  parameter int ZERO_PR   = 31
) (
  input  logic        clock,
  input  logic        reset,
  map_table_if.slave  mt
);
  localparam int AR_W = $clog2(NUM_ARCH);
  localparam int PR_W = $clog2(NUM_PR);

  logic [NUM_ARCH-1:0][PR_W-1:0]   spec_map, spec_nxt;
  logic [NUM_ARCH-1:0][PR_W-1:0]   arch_map, arch_nxt;
  logic [NUM_ARCH-1:0]             ready, rdy_nxt;

  logic [NUM_SUPER-1:0]            bypA, bypB;
  logic [NUM_SUPER-1:0][PR_W-1:0]  bypA_tag, bypB_tag, told;
  logic [NUM_SUPER-1:0][PR_W-1:0]  t1, t2;
  logic [NUM_SUPER-1:0]            r1, r2;

  // Intra-group dependencies: the youngest older slot writing the same arch
  // register supplies the tag (later j overrides earlier).
  always_comb begin
    bypA = '0; bypB = '0; bypA_tag = '0; bypB_tag = '0; told = '0;
    for (int s = 0; s < NUM_SUPER; s++) begin
      told[s] = spec_map[mt.dest_idx[s]];
      for (int j = 0; j < NUM_SUPER; j++) begin
        if (j < s && mt.dest_idx[j] != AR_W'(ZERO_REG)) begin
          if (mt.dest_idx[j] == mt.srcA_idx[s]) begin bypA[s] = 1'b1; bypA_tag[s] = mt.T_idx[j]; end
          if (mt.dest_idx[j] == mt.srcB_idx[s]) begin bypB[s] = 1'b1; bypB_tag[s] = mt.T_idx[j]; end
          if (mt.dest_idx[j] == mt.dest_idx[s]) told[s] = mt.T_idx[j];
        end
      end
      if (mt.dest_idx[s] == AR_W'(ZERO_REG)) told[s] = PR_W'(ZERO_PR);
    end
  end

  for (genvar s = 0; s < NUM_SUPER; s++) begin : g_slot
    map_table_src #(.NUM_SUPER(NUM_SUPER), .AR_W(AR_W), .PR_W(PR_W),
                    .ZERO_REG(ZERO_REG), .ZERO_PR(ZERO_PR)) u_srcA (
      .src(mt.srcA_idx[s]), .tbl_tag(spec_map[mt.srcA_idx[s]]), .tbl_rdy(ready[mt.srcA_idx[s]]),
      .byp_hit(bypA[s]), .byp_tag(bypA_tag[s]),
      .cdb_valid(mt.CDB_valid), .cdb_tag(mt.CDB_T_idx),
      .tag(t1[s]), .rdy(r1[s])
    );
    map_table_src #(.NUM_SUPER(NUM_SUPER), .AR_W(AR_W), .PR_W(PR_W),
                    .ZERO_REG(ZERO_REG), .ZERO_PR(ZERO_PR)) u_srcB (
      .src(mt.srcB_idx[s]), .tbl_tag(spec_map[mt.srcB_idx[s]]), .tbl_rdy(ready[mt.srcB_idx[s]]),
      .byp_hit(bypB[s]), .byp_tag(bypB_tag[s]),
      .cdb_valid(mt.CDB_valid), .cdb_tag(mt.CDB_T_idx),
      .tag(t2[s]), .rdy(r2[s])
    );
  end

  assign mt.T1_idx   = t1;
  assign mt.T2_idx   = t2;
  assign mt.T1_ready = r1;
  assign mt.T2_ready = r2;
  assign mt.Told_idx = told;

  // Retirement map next state. A slot retires only if every older slot does,
  // so an isolated upper-slot enable is ignored.
  always_comb begin
    logic ok;
    arch_nxt = arch_map;
    ok       = 1'b1;
    for (int s = 0; s < NUM_SUPER; s++) begin
      ok = ok & mt.retire_en[s];
      if (ok && mt.retire_dest_idx[s] != AR_W'(ZERO_REG))
        arch_nxt[mt.retire_dest_idx[s]] = mt.retire_T_idx[s];
    end
  end

  // Speculative map next state. Rollback restores from arch_nxt so retirements
  // in the same cycle are not lost. CDB wakeup matches against the current map,
  // then dispatch writes override (younger slots last).
  always_comb begin
    spec_nxt = spec_map;
    rdy_nxt  = ready;
    if (mt.rollback_en) begin
      spec_nxt = arch_nxt;
      rdy_nxt  = '1;
    end else begin
      for (int i = 0; i < NUM_ARCH; i++)
        for (int l = 0; l < NUM_SUPER; l++)
          if (mt.CDB_valid[l] && mt.CDB_T_idx[l] != PR_W'(ZERO_PR) && spec_map[i] == mt.CDB_T_idx[l])
            rdy_nxt[i] = 1'b1;
      if (mt.dispatch_en)
        for (int s = 0; s < NUM_SUPER; s++)
          if (mt.dest_idx[s] != AR_W'(ZERO_REG)) begin
            spec_nxt[mt.dest_idx[s]] = mt.T_idx[s];
            rdy_nxt[mt.dest_idx[s]]  = 1'b0;
          end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        spec_map[i] <= PR_W'(i);
        arch_map[i] <= PR_W'(i);
      end
      spec_map[ZERO_REG] <= PR_W'(ZERO_PR);
      arch_map[ZERO_REG] <= PR_W'(ZERO_PR);
      ready <= '1;
    end else begin
      spec_map <= spec_nxt;
      arch_map <= arch_nxt;
      ready    <= rdy_nxt;
    end
  end
endmodule

// File: tb/tb_map_table.sv
module tb_map_table;
  localparam int NS = 2;
  localparam int ZR = 31;
  localparam int ZP = 31;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  map_table_if bus ();
  map_table dut (.clock(clock), .reset(reset), .mt(bus));

  typedef struct packed {
    logic [1:0][5:0] t1, t2, told;
    logic [1:0]      r1, r2;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: arch register -> physical tag, plus readiness.
  int spec_m[32];
  int arch_m[32];
  int rdy_m[32];

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: outputs are combinational and always presented; sample mid-cycle.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("T1_idx",   16'(bus.T1_idx),   16'(e.t1));
      chk("T2_idx",   16'(bus.T2_idx),   16'(e.t2));
      chk("T1_ready", 16'(bus.T1_ready), 16'(e.r1));
      chk("T2_ready", 16'(bus.T2_ready), 16'(e.r2));
      chk("Told_idx", 16'(bus.Told_idx), 16'(e.told));
    end
  end

  function automatic void lookup(input int s, input int src, output int tag, output int r);
    if (src == ZR) begin tag = ZP; r = 1; return; end
    if (s == 1 && int'(bus.dest_idx[0]) != ZR && src == int'(bus.dest_idx[0])) begin
      tag = int'(bus.T_idx[0]); r = 0; return;
    end
    tag = spec_m[src];
    r   = rdy_m[src];
    for (int l = 0; l < NS; l++)
      if (bus.CDB_valid[l] && int'(bus.CDB_T_idx[l]) != ZP && int'(bus.CDB_T_idx[l]) == tag) r = 1;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    int tg, r, d;
    e = '0;
    for (int s = 0; s < NS; s++) begin
      lookup(s, int'(bus.srcA_idx[s]), tg, r); e.t1[s] = 6'(tg); e.r1[s] = 1'(r);
      lookup(s, int'(bus.srcB_idx[s]), tg, r); e.t2[s] = 6'(tg); e.r2[s] = 1'(r);
      d = int'(bus.dest_idx[s]);
      if (d == ZR) e.told[s] = 6'(ZP);
      else if (s == 1 && d == int'(bus.dest_idx[0])) e.told[s] = bus.T_idx[0];
      else e.told[s] = 6'(spec_m[d]);
    end
    return e;
  endfunction

  task automatic model_clock();
    int nr[32];
    if (reset) begin
      for (int i = 0; i < 32; i++) begin spec_m[i] = i; arch_m[i] = i; rdy_m[i] = 1; end
      return;
    end
    if (bus.retire_en[0] && int'(bus.retire_dest_idx[0]) != ZR)
      arch_m[bus.retire_dest_idx[0]] = int'(bus.retire_T_idx[0]);
    if (bus.retire_en[0] && bus.retire_en[1] && int'(bus.retire_dest_idx[1]) != ZR)
      arch_m[bus.retire_dest_idx[1]] = int'(bus.retire_T_idx[1]);
    if (bus.rollback_en) begin
      for (int i = 0; i < 32; i++) begin spec_m[i] = arch_m[i]; rdy_m[i] = 1; end
      return;
    end
    nr = rdy_m;
    for (int i = 0; i < 32; i++)
      for (int l = 0; l < NS; l++)
        if (bus.CDB_valid[l] && int'(bus.CDB_T_idx[l]) != ZP && spec_m[i] == int'(bus.CDB_T_idx[l])) nr[i] = 1;
    if (bus.dispatch_en)
      for (int s = 0; s < NS; s++)
        if (int'(bus.dest_idx[s]) != ZR) begin
          spec_m[bus.dest_idx[s]] = int'(bus.T_idx[s]);
          nr[bus.dest_idx[s]] = 0;
        end
    rdy_m = nr;
  endtask

  task automatic step(input bit do_chk);
    if (do_chk) q.push_back(expect_now());
    @(posedge clock);
    model_clock();
    #1;
  endtask

  task automatic idle();
    reset = 0;
    bus.dispatch_en = 0; bus.rollback_en = 0;
    bus.dest_idx = {5'(ZR), 5'(ZR)};
    bus.srcA_idx = '0; bus.srcB_idx = '0;
    bus.T_idx = {6'(ZP), 6'(ZP)};
    bus.CDB_valid = '0; bus.CDB_T_idx = '0;
    bus.retire_en = '0; bus.retire_dest_idx = '0; bus.retire_T_idx = '0;
  endtask

  function automatic logic [5:0] rtag();
    int t;
    t = $urandom_range(0, 62);
    if (t >= ZP) t++;
    return 6'(t);
  endfunction

  function automatic logic [4:0] rarch();
    return ($urandom_range(0, 4) == 0) ? 5'(ZR) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    reset = 1;
    step(0);                      // state unknown before the first reset edge
    idle();

    // identity map after reset
    bus.srcA_idx = {5'd7, 5'd5}; bus.srcB_idx = {5'd2, 5'd1}; bus.dest_idx = {5'(ZR), 5'd3};
    step(1);
    // dispatch r3->32, r4->33 then read them
    bus.dispatch_en = 1; bus.dest_idx = {5'd4, 5'd3}; bus.T_idx = {6'd33, 6'd32};
    step(1);
    idle(); bus.srcA_idx = {5'd4, 5'd3};
    step(1);
    // intra-group bypass and WAW in one group
    bus.dispatch_en = 1; bus.dest_idx = {5'd3, 5'd3}; bus.T_idx = {6'd41, 6'd40};
    bus.srcA_idx = {5'd3, 5'd3};
    step(1);
    idle(); bus.srcA_idx = {5'd3, 5'd3};
    step(1);
    // remap r3->32, then CDB wakeup same cycle as read, then persisted
    bus.dispatch_en = 1; bus.dest_idx = {5'(ZR), 5'd3}; bus.T_idx = {6'(ZP), 6'd32};
    step(1);
    idle(); bus.srcA_idx = {5'd3, 5'd3}; bus.CDB_valid = 2'b01; bus.CDB_T_idx = {6'd0, 6'd32};
    step(1);
    idle(); bus.srcA_idx = {5'd3, 5'd3};
    step(1);
    // retire r3->32, dispatch r3->45, rollback with retire r4->33 and dispatch
    bus.retire_en = 2'b01; bus.retire_dest_idx = {5'd0, 5'd3}; bus.retire_T_idx = {6'd0, 6'd32};
    step(1);
    idle(); bus.dispatch_en = 1; bus.dest_idx = {5'(ZR), 5'd3}; bus.T_idx = {6'(ZP), 6'd45};
    step(1);
    idle(); bus.rollback_en = 1; bus.dispatch_en = 1;
    bus.dest_idx = {5'd5, 5'd3}; bus.T_idx = {6'd51, 6'd50};
    bus.retire_en = 2'b01; bus.retire_dest_idx = {5'd0, 5'd4}; bus.retire_T_idx = {6'd0, 6'd33};
    step(1);
    idle(); bus.srcA_idx = {5'd4, 5'd3}; bus.srcB_idx = {5'd6, 5'd5};
    step(1);
    // zero register everywhere
    bus.dispatch_en = 1; bus.dest_idx = {5'(ZR), 5'(ZR)}; bus.T_idx = {6'(ZP), 6'(ZP)};
    bus.srcA_idx = {5'(ZR), 5'(ZR)}; bus.srcB_idx = {5'(ZR), 5'(ZR)};
    step(1);
    idle(); bus.srcA_idx = {5'(ZR), 5'd3}; bus.srcB_idx = {5'd4, 5'(ZR)};
    step(1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset           = ($urandom_range(0, 299) == 0);
      bus.rollback_en = ($urandom_range(0, 19) == 0);
      bus.dispatch_en = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < NS; s++) begin
        bus.dest_idx[s] = rarch();
        bus.T_idx[s]    = (bus.dest_idx[s] == 5'(ZR)) ? 6'(ZP) : rtag();
        bus.srcA_idx[s] = rarch();
        bus.srcB_idx[s] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : rarch();
        bus.CDB_valid[s] = 1'($urandom_range(0, 1));
        bus.CDB_T_idx[s] = ($urandom_range(0, 3) != 0) ? 6'(spec_m[$urandom_range(0, 7)]) : rtag();
        bus.retire_dest_idx[s] = rarch();
        bus.retire_T_idx[s]    = rtag();
      end
      case ($urandom_range(0, 3))
        0: bus.retire_en = 2'b00;
        1: bus.retire_en = 2'b01;
        2: bus.retire_en = 2'b11;
        default: bus.retire_en = 2'b10;
      endcase
      step(1);
    end
    idle();
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0 entries", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/map_table.md
Name: map_table

Overview:
- 2-wide register rename map table; sits directly downstream of the free list.
- Consumes FL-allocated tags T_idx and decoder dest/src indices, and produces renamed source tags with ready bits plus Told_idx for the ROB.
- Keeps an internal retirement (architectural) map updated at ROB retire.
- On rollback, the speculative map is restored from the retirement map, matching free-list tail rollback.

Parameters:
NUM_SUPER, 2, dispatch/retire/CDB width
NUM_ARCH, 32, architectural registers
NUM_PR, 64, physical registers
ZERO_REG, 31, architectural zero register (never renamed)
ZERO_PR, 31, physical tag standing for zero register (always ready)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
dispatch_en  in  1  commit rename of current group this cycle
rollback_en  in  1  mispredict recovery at ROB head
dest_idx  in  NUM_SUPER x 5  arch dest per slot (ZERO_REG = none)
srcA_idx  in  NUM_SUPER x 5  arch source A per slot
srcB_idx  in  NUM_SUPER x 5  arch source B per slot
T_idx  in  NUM_SUPER x 6  new tags from free list (ZERO_PR where dest = ZERO_REG)
CDB_valid  in  NUM_SUPER  completion broadcast valid per lane
CDB_T_idx  in  NUM_SUPER x 6  completing tag per lane
retire_en  in  NUM_SUPER  retire per slot (slot1 only with slot0)
retire_dest_idx  in  NUM_SUPER x 5  arch dest of retiring instruction
retire_T_idx  in  NUM_SUPER x 6  tag of retiring instruction
T1_idx, T2_idx  out  NUM_SUPER x 6  renamed source A/B tags
T1_ready, T2_ready  out  NUM_SUPER  source ready bits
Told_idx  out  NUM_SUPER x 6  previous mapping of dest (to ROB)

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clock.
- State:
  - spec_map[NUM_ARCH] x 6 and ready[NUM_ARCH].
  - arch_map[NUM_ARCH] x 6.
- Reset:
  - spec_map[i] = i, arch_map[i] = i, ready[i] = 1.
  - Outputs are combinational from state, so after reset they reflect the identity map with all ready.
- Rename (combinational, same cycle as dispatch):
  - Slot0 sources read spec_map/ready directly.
  - Slot1 source equal to slot0 dest (dest != ZERO_REG) gets T_idx[0], ready = 0 (intra-group bypass).
  - Source ZERO_REG gives ZERO_PR, ready = 1, regardless of table.
  - Ready bypass: a source whose tag matches a valid CDB_T_idx this cycle reads ready = 1. This does not apply to the intra-group slot0 bypass.
- Told:
  - Told_idx[s] = spec_map[dest_idx[s]]; ZERO_PR if dest = ZERO_REG.
  - Told_idx[1] = T_idx[0] when dest_idx[1] == dest_idx[0] != ZERO_REG.
- Update at posedge when dispatch_en && !rollback_en:
  - spec_map[dest] <= T_idx and ready[dest] <= 0 per slot with dest != ZERO_REG.
  - Same dest in both slots: slot1 wins.
  - Outputs are driven regardless of dispatch_en; state changes only when it is set.
- CDB:
  - For every arch i with spec_map[i] == valid CDB_T_idx, set ready[i] <= 1.
  - Dispatch write of the same arch in the same cycle overrides (ready 0).
  - CDB with tag ZERO_PR is ignored.
- Retire:
  - arch_map[retire_dest_idx[s]] <= retire_T_idx[s] for enabled slots with dest != ZERO_REG.
  - Same dest in both slots: slot1 wins.
  - retire_en = 2'b10 is illegal; slot1 is ignored.
- Rollback (priority over dispatch and CDB):
  - spec_map <= next arch_map, including this cycle's retirements; all ready <= 1.
  - Dispatch is dropped that cycle.
- ZERO_REG entry is never written; it stays ZERO_PR/ready.
- Reset asserted mid-operation overrides all inputs that cycle.

Test Plan:
- Reset then no dispatch -> srcA_idx = {5,7} give T1_idx = {5,7}, T1_ready = 2'b11; Told for dest 3 = 3.
- Dispatch dest = {3,4}, T_idx = {32,33}, then next cycle srcA = {3,4} -> T1_idx = {32,33}, ready = 00; Told was {3,4}.
- Same group: dest0 = 3, T0 = 40; slot1 srcA = 3, dest1 = 3, T1 = 41 -> T1_idx[1] = 40, ready 0; Told_idx[1] = 40; next cycle spec_map[3] = 41.
- After mapping r3 -> 32: CDB_valid = 01, CDB_T_idx[0] = 32 same cycle as reading r3 -> ready = 1 combinationally; stays 1 next cycle.
- Retire r3 -> 32, then dispatch r3 -> 45, then rollback_en with simultaneous retire r4 -> 33 -> spec_map[3] = 32, spec_map[4] = 33, all ready = 1; concurrent dispatch ignored.
- Dest/src ZERO_REG (31) in both slots with dispatch -> outputs ZERO_PR/ready = 1, Told = ZERO_PR; table unchanged.
